// File: rtl/bcd_pkg.sv
// bcd_pkg: shared widths, limits and FSM state encoding for the binary-to-BCD converter.
package bcd_pkg;
  localparam int BIN_W = 14;
  localparam int DIGITS = 4;
  localparam int MAX_VAL = 9999;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 when the digit is 5 or more.
module bcd_add3 (
  input  logic [3:0] din_i,
  output logic [3:0] dout_o
);
  assign dout_o = (din_i >= 4'd5) ? din_i + 4'd3 : din_i;
endmodule

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential 14-bit binary to 4-digit BCD converter, one bit per clock.
// Define BIN_TO_BCD_OVF_EN to saturate inputs above 9999 to 9999 and raise ovf.
module bin_to_bcd
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [3:0]       hundred,
  output logic [3:0]       thousand,
  output logic             ovf
);
`ifdef BIN_TO_BCD_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  state_t                state_q;
  logic [BIN_W-1:0]      sh_q;
  logic [4*DIGITS-1:0]   scr_q, adj, scr_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  big_q;
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (.din_i(scr_q[4*g +: 4]), .dout_o(adj[4*g +: 4]));
    end
  endgenerate
  // The carry out of the thousands digit is dropped, leaving bin mod 10000.
  assign scr_d = {adj[4*DIGITS-2:0], sh_q[BIN_W-1]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      big_q <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      {thousand, hundred, tens, ones} <= '0;
      ovf <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= SHIFT;
          sh_q <= bin;
          scr_q <= '0;
          cnt_q <= '0;
          big_q <= bin > BIN_W'(MAX_VAL);
          busy <= 1'b1;
        end
        SHIFT: begin
          scr_q <= scr_d;
          sh_q <= sh_q << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BIN_W - 1)) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          {thousand, hundred, tens, ones} <= (OVF_EN && big_q) ? {DIGITS{4'd9}} : scr_q;
          ovf <= OVF_EN && big_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin_to_bcd.sv
// tb_bin_to_bcd: randomized self-checking bench against an arithmetic decimal model.
module tb_bin_to_bcd;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, busy, done, ovf;
  logic [13:0] bin = '0;
  logic [3:0] ones, tens, hundred, thousand;
  int n_vec = 0, n_bad = 0;
  logic [16:0] last_exp = '0;

  bin_to_bcd dut (.clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy),
    .done(done), .ones(ones), .tens(tens), .hundred(hundred), .thousand(thousand), .ovf(ovf));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model(input int v);
    int e;
    bit o;
`ifdef BIN_TO_BCD_OVF_EN
    o = v > 9999;
    e = o ? 9999 : v;
`else
    o = 0;
    e = v % 10000;
`endif
    model = {o, 4'(e / 1000), 4'((e / 100) % 10), 4'((e / 10) % 10), 4'(e % 10)};
  endfunction

  function automatic logic [16:0] outs();
    outs = {ovf, thousand, hundred, tens, ones};
  endfunction

  // mode 0: single start pulse; 1: intruding starts with bin=5; 2: start held high, junk bin while busy
  task automatic conv(input logic [13:0] v, input int mode);
    int bad_run = 0;
    logic [16:0] e;
    e = model(int'(v));
    start = 1'b1;
    bin = v;
    @(posedge clk);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0 || outs() !== last_exp) bad_run++;
      start = (mode == 2) || (mode == 1 && (c == 2 || c == 9));
      bin = (mode == 0) ? v : (mode == 1) ? 14'd5 : 14'($urandom);
    end
    @(negedge clk);
    check("run_busy_hold", bad_run, 0);
    check("done_pulse", {busy, done}, 2'b01);
    check("result", outs(), e);
    check("digit_range", (thousand <= 9 && hundred <= 9 && tens <= 9 && ones <= 9), 1);
    last_exp = e;
    if (mode != 2) begin
      start = 1'b0;
      @(negedge clk);
      check("done_clear", {busy, done}, 2'b00);
    end
  endtask

  initial begin
    int n_done;
    repeat (3) @(negedge clk);
    check("reset_outs", {busy, done, outs()}, '0);
    rst = 1'b0;
    conv(14'd0, 0);
    conv(14'd1234, 0);
    conv(14'd9999, 1);
    conv(14'd5, 0);
    conv(14'd12345, 0);
    conv(14'd4321, 0);
    start = 1'b1;
    bin = 14'd4321;
    @(posedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_reset_outs", {busy, done, outs()}, '0);
    last_exp = '0;
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("no_done_after_reset", n_done, 0);
    conv(14'd4321, 0);
    conv(14'd0, 2);
    conv(14'd9999, 2);
    conv(14'd10000, 2);
    conv(14'd16383, 2);
    for (int i = 0; i < 400; i++) conv(14'($urandom), 2);
    start = 1'b0;
    @(negedge clk);
    check("final_idle", {busy, done}, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
